// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// ALU and load writeback, with a registered write slot and read forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int X0_GUARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              last_grant
);

  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              granted;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  logic              g_wen;

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    grant0 = !reset && !hold && req0_valid
           && (!req1_valid || !prio);
    grant1 = !reset && !hold && req1_valid
           && (!req0_valid || prio);
    granted = grant0 || grant1;
    g_rd    = grant1 ? req1_rd : req0_rd;
    g_data  = grant1 ? req1_data : req0_data;
    g_wen   = !((X0_GUARD != 0) && (g_rd == '0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd         <= '0;
      writeData  <= '0;
      regWrite   <= 1'b0;
      prio       <= 1'b0;
      last_grant <= 1'b0;
    end else if (granted) begin
      rd         <= g_rd;
      writeData  <= g_data;
      regWrite   <= g_wen;
      prio       <= ~grant1;
      last_grant <= grant1;
    end else begin
      regWrite   <= 1'b0;
    end
  end

  assign fwd1_hit = regWrite && (rs1 == rd);
  assign fwd2_hit = regWrite && (rs2 == rd);
  assign fwd_data = writeData;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change on the falling edge; outputs are sampled off the rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic        regWrite;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd_data;
  logic        last_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .X0_GUARD(1)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rd(req1_rd), .req1_data(req1_data),
    .rd(rd), .writeData(writeData), .regWrite(regWrite),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd_data(fwd_data), .last_grant(last_grant)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    hold       = 1'b0;
    req0_valid = 1'b1;
    req0_rd    = 5'd15;
    req0_data  = 32'h1234_5678;
    req1_valid = 1'b1;
    req1_rd    = 5'd20;
    req1_data  = 32'hABCD_EF12;
    rs1        = 5'd0;
    rs2        = 5'd0;

    // reset with both requesters valid
    repeat (2) tick();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_wen", regWrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_last", last_grant, 0);

    // release: round robin alternation starting at req0
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), req0_ready, (i % 2 == 0));
      chk($sformatf("rr_rdy1_%0d", i), req1_ready, (i % 2 == 1));
      tick();
      chk($sformatf("rr_wen_%0d", i), regWrite, 1);
      chk($sformatf("rr_rd_%0d", i), rd, (i % 2 == 0) ? 15 : 20);
      chk($sformatf("rr_wd_%0d", i), writeData,
          (i % 2 == 0) ? 32'h1234_5678 : 32'hABCD_EF12);
      chk($sformatf("rr_last_%0d", i), last_grant, i % 2);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("drain_wen", regWrite, 0);
    chk("drain_rd_hold", rd, 20);
    chk("drain_wd_hold", writeData, 32'hABCD_EF12);

    // x0 write from req1: handshake completes, no write enable
    @(negedge clk);
    req1_valid = 1'b1;
    req1_rd    = 5'd0;
    req1_data  = 32'hDEAD_BEEF;
    #1;
    chk("x0_rdy1", req1_ready, 1);
    chk("x0_rdy0", req0_ready, 0);
    tick();
    chk("x0_wen", regWrite, 0);
    chk("x0_fwd1", fwd1_hit, 0);
    chk("x0_fwd2", fwd2_hit, 0);
    chk("x0_last", last_grant, 1);

    // forwarding of an in-flight write
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_rd    = 5'd5;
    req0_data  = 32'hCAFE_0001;
    rs1        = 5'd5;
    rs2        = 5'd10;
    tick();
    chk("fw_wen", regWrite, 1);
    chk("fw_hit1", fwd1_hit, 1);
    chk("fw_hit2", fwd2_hit, 0);
    chk("fw_data", fwd_data, 32'hCAFE_0001);
    @(negedge clk);
    req0_valid = 1'b0;
    tick();
    chk("fw_hit1_off", fwd1_hit, 0);
    chk("fw_hit2_off", fwd2_hit, 0);

    // hold blocks all grants and keeps prio (now 1)
    @(negedge clk);
    hold       = 1'b1;
    req0_valid = 1'b1;
    req0_rd    = 5'd15;
    req0_data  = 32'h1234_5678;
    req1_valid = 1'b1;
    req1_rd    = 5'd20;
    req1_data  = 32'hABCD_EF12;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_rdy0_%0d", i), req0_ready, 0);
      chk($sformatf("hold_rdy1_%0d", i), req1_ready, 0);
      tick();
      chk($sformatf("hold_wen_%0d", i), regWrite, 0);
      chk($sformatf("hold_last_%0d", i), last_grant, 0);
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    chk("unhold_rdy1", req1_ready, 1);
    chk("unhold_rdy0", req0_ready, 0);

    // reset mid-write discards the slot immediately
    tick();
    chk("pre_rst_wen", regWrite, 1);
    chk("pre_rst_rd", rd, 20);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wen", regWrite, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_wd", writeData, 0);
    chk("mid_rst_rdy0", req0_ready, 0);
    chk("mid_rst_rdy1", req1_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    tick();
    chk("post_rst_rd", rd, 15);
    chk("post_rst_last", last_grant, 0);

    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
